imem_fetch_ctrl: RTL
====================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch byte address after reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 32, the number of valid instruction-memory words.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port imem_addr  output  32  byte address driven to instruction memory.
REQ-006 SHALL have port imem_instr  input  32  instruction word returned combinationally for imem_addr.
REQ-007 SHALL have port halt  input  1  when 1, no new fetches are issued.
REQ-008 SHALL have port redirect  input  1  branch/jump request, flushing the buffer.
REQ-009 SHALL have port redirect_pc  input  32  target byte address, sampled when redirect=1.
REQ-010 SHALL have port instr_valid  output  1  buffer head is valid.
REQ-011 SHALL have port instr_ready  input  1  decode accepts the head this cycle.
REQ-012 SHALL have port instr  output  32  buffer-head instruction word.
REQ-013 SHALL have port instr_pc  output  32  byte address of the buffer-head instruction.
REQ-014 SHALL have port fault  output  1  sticky fetch fault, either misaligned or out-of-range.

Function
REQ-015 SHALL hold fetch pointer fpc (32 bit); imem_addr SHALL equal fpc combinationally at all times.
REQ-016 SHALL hold a 2-entry FIFO of {instr, pc}, with count 0..2; instr_valid = (count != 0); instr/instr_pc SHALL show the head entry, or 0 when empty.
REQ-017 Pop SHALL occur on a cycle with instr_valid=1 and instr_ready=1.
REQ-018 SHALL have states RUN, HALTED and FAULT, encoded in 2 bits.
REQ-019 Fetch condition SHALL be: state=RUN, and (count<2 or pop), and fpc legal. Legal means fpc[1:0]=0 and (fpc>>2) < IMEM_WORDS.
REQ-020 On a fetch, SHALL push {imem_instr, fpc} and set fpc <= fpc+4, modulo 2^32 (wrap to 0, no carry out).
REQ-021 Push and pop in the same cycle with count=2 SHALL be legal; count stays 2 and order is preserved.
REQ-022 In RUN, if fpc is illegal, SHALL enter FAULT with no push; fault=1 from the next cycle.
REQ-023 RUN -> HALTED when halt=1 and redirect=0; HALTED -> RUN when halt=0. No fetch SHALL occur in a cycle with halt=1.
REQ-024 FAULT SHALL persist until a legal redirect or reset; while in FAULT the buffer SHALL still drain via pops.
REQ-025 Redirect SHALL take highest priority, in any state:
- count <= 0, with no push that cycle;
- fpc <= redirect_pc;
- a pop coinciding with redirect counts as consumed, and the entry is discarded.
REQ-026 The state after a redirect SHALL be:
- FAULT if redirect_pc is illegal;
- otherwise HALTED if halt=1;
- otherwise RUN, with fault cleared.
REQ-027 Latency: redirect asserted in cycle N SHALL give instr_valid=1, instr_pc=redirect_pc in cycle N+2, assuming halt=0 and the target is legal.
REQ-028 Steady state with instr_ready held 1 SHALL deliver one instruction per cycle, with no bubbles.
REQ-029 instr_pc of consecutive pops SHALL increase by 4 unless separated by a redirect.

Reset
REQ-030 rst=1 SHALL immediately force: fpc=RESET_PC, count=0, state=RUN, fault=0, instr_valid=0, instr=0, instr_pc=0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries, with no pop reported afterwards.
REQ-032 The first push after reset deassertion SHALL occur on the first rising edge with rst=0; instr_valid=1 follows that edge.

Verification
REQ-033 Stream: memory word k = k; rst release, instr_ready=1 -> instr_pc 0,4,8,... and instr 0,1,2,..., one per cycle.
REQ-034 Backpressure: instr_ready=0 for 5 cycles -> count saturates at 2, fpc=8; on release, pops deliver pc 0,4,8 in order with no loss.
REQ-035 Redirect: redirect=1, redirect_pc=0x40 with a full buffer -> instr_valid=0 next cycle, instr_pc=0x40 two cycles later.
REQ-036 Fault: run to pc 0x7C (IMEM_WORDS=32) -> 0x7C delivered, fault=1, no 0x80 entry; a later redirect to 0x10 -> fault=0 and fetch resumes at 0x10.
REQ-037 Misaligned redirect_pc=0x6 -> FAULT, fault=1, buffer empty; halt=1 for 3 cycles in RUN -> fpc frozen and no pushes.
REQ-038 Async reset pulse between clock edges with 2 entries buffered -> instr_valid=0 immediately and fpc=RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: walks a fetch pointer through instruction
// memory, buffers up to two fetched {instr, pc} entries for decode, and
// handles halt, redirect and illegal-address faults.
//
// Handshake: an entry moves to decode on every cycle where instr_valid=1 and
// instr_ready=1. instr_valid does not depend on instr_ready. instr and
// instr_pc stay stable while instr_valid=1 and instr_ready=0, unless a
// redirect or reset flushes the buffer.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fault,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [31:0] WORDS = 32'(IMEM_WORDS);

  state_t      state;
  logic [31:0] fpc;
  logic [1:0]  count;
  logic [31:0] e0_instr, e0_pc;
  logic [31:0] e1_instr, e1_pc;

  logic fpc_legal;
  logic rpc_legal;
  logic pop;
  logic fetch;

  // Address legality, handshake and fetch decision for this cycle.
  always_comb begin
    fpc_legal = (fpc[1:0] == 2'b00) && ((fpc >> 2) < WORDS);
    rpc_legal = (redirect_pc[1:0] == 2'b00) && ((redirect_pc >> 2) < WORDS);
    pop       = (count != 2'd0) && instr_ready;
    fetch     = (state == RUN) && !halt && !redirect && fpc_legal &&
                ((count != 2'd2) || pop);
  end

  // Outputs: memory address follows the fetch pointer; head entry or zeros.
  always_comb begin
    imem_addr   = fpc;
    instr_valid = (count != 2'd0);
    instr       = (count != 2'd0) ? e0_instr : 32'd0;
    instr_pc    = (count != 2'd0) ? e0_pc    : 32'd0;
    dbg_state   = state;
  end

  // Control FSM: fetch pointer, state and sticky fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      fpc   <= RESET_PC;
      fault <= 1'b0;
    end else if (redirect) begin
      // Redirect wins in every state and decides the next state by target.
      fpc <= redirect_pc;
      if (!rpc_legal) begin
        state <= FAULT;
        fault <= 1'b1;
      end else begin
        state <= halt ? HALTED : RUN;
        fault <= 1'b0;
      end
    end else begin
      case (state)
        RUN: begin
          if (!fpc_legal) begin
            state <= FAULT;
            fault <= 1'b1;
          end else if (halt) begin
            state <= HALTED;
          end else if (fetch) begin
            fpc <= fpc + 32'd4;
          end
        end
        HALTED: begin
          if (!halt) state <= RUN;
        end
        default: begin
          // FAULT holds until a legal redirect or reset.
          state <= FAULT;
        end
      endcase
    end
  end

  // Two-entry buffer: pop shifts entry 1 to the head, push fills the next slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 2'd0;
      e0_instr <= 32'd0;
      e0_pc    <= 32'd0;
      e1_instr <= 32'd0;
      e1_pc    <= 32'd0;
    end else if (redirect) begin
      count <= 2'd0;
    end else begin
      case ({pop, fetch})
        2'b10: begin
          e0_instr <= e1_instr;
          e0_pc    <= e1_pc;
          count    <= count - 2'd1;
        end
        2'b01: begin
          if (count == 2'd0) begin
            e0_instr <= imem_instr;
            e0_pc    <= fpc;
          end else begin
            e1_instr <= imem_instr;
            e1_pc    <= fpc;
          end
          count <= count + 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0_instr <= imem_instr;
            e0_pc    <= fpc;
          end else begin
            e0_instr <= e1_instr;
            e0_pc    <= e1_pc;
            e1_instr <= imem_instr;
            e1_pc    <= fpc;
          end
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

endmodule
